// File: rtl/vanilla_returned_resp_buffer.sv
// Sorts returned packets: float/ifetch/credit pass straight through, int loads go into a small FIFO.
// Latency: float/ifetch/credit zero cycles (combinational); int loads are visible at the FIFO head one cycle after enqueue.
// Backpressure: only int loads stall (returned_yumi_o=0) when the FIFO is full; there is no full-bypass and no empty-bypass.
module vanilla_returned_resp_buffer #(
    // The instantiating design is expected to set data_width_p explicitly.
    parameter int data_width_p      = 32,
    parameter int reg_addr_width_p  = 5,
    parameter int els_p             = 4,
    parameter int force_threshold_p = els_p - 1,
    localparam int cnt_w_lp         = $clog2(els_p + 1),
    localparam int ptr_w_lp         = $clog2(els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        returned_v_i,
    input  logic [data_width_p-1:0]     returned_data_i,
    input  logic [reg_addr_width_p-1:0] returned_reg_id_i,
    input  logic [1:0]                  returned_pkt_type_i,
    output logic                        returned_yumi_o,

    output logic                        int_resp_v_o,
    output logic [reg_addr_width_p-1:0] int_resp_rd_o,
    output logic [data_width_p-1:0]     int_resp_data_o,
    output logic                        int_resp_force_o,
    input  logic                        int_resp_yumi_i,

    output logic                        float_resp_v_o,
    output logic [reg_addr_width_p-1:0] float_resp_rd_o,
    output logic [data_width_p-1:0]     float_resp_data_o,

    output logic                        ifetch_v_o,
    output logic [data_width_p-1:0]     ifetch_instr_o,

    output logic [cnt_w_lp-1:0]         int_count_o
);

    localparam logic [cnt_w_lp-1:0] els_lp   = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] thresh_lp = cnt_w_lp'(force_threshold_p);

    logic [ptr_w_lp-1:0]         wptr_q, wptr_d;
    logic [ptr_w_lp-1:0]         rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]         count_q, count_d;

    // Payload storage carries no reset; occupancy alone decides what is valid.
    logic [data_width_p-1:0]     data_mem_q [els_p];
    logic [reg_addr_width_p-1:0] rd_mem_q   [els_p];

    logic is_int, is_float, is_ifetch;
    logic has_room, enq, deq;

    assign is_int    = (returned_pkt_type_i == 2'd0);
    assign is_float  = (returned_pkt_type_i == 2'd1);
    assign is_ifetch = (returned_pkt_type_i == 2'd2);

    // Handshakes and valids, all forced low while reset is held.
    always_comb begin
        has_room         = (count_q < els_lp);
        returned_yumi_o  = ~reset_i & returned_v_i & (~is_int | has_room);
        enq              = returned_yumi_o & is_int;
        int_resp_v_o     = ~reset_i & (count_q != '0);
        deq              = int_resp_v_o & int_resp_yumi_i;
        int_resp_force_o = ~reset_i & (count_q >= thresh_lp);
        float_resp_v_o   = ~reset_i & returned_v_i & is_float;
        ifetch_v_o       = ~reset_i & returned_v_i & is_ifetch;
    end

    assign float_resp_rd_o   = returned_reg_id_i;
    assign float_resp_data_o = returned_data_i;
    assign ifetch_instr_o    = returned_data_i;
    assign int_resp_rd_o     = rd_mem_q[rptr_q];
    assign int_resp_data_o   = data_mem_q[rptr_q];
    assign int_count_o       = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally since els_p is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (enq) wptr_d = wptr_q + ptr_w_lp'(1);
        if (deq) rptr_d = rptr_q + ptr_w_lp'(1);
        if (enq && !deq)      count_d = count_q + cnt_w_lp'(1);
        else if (!enq && deq) count_d = count_q - cnt_w_lp'(1);
    end

    // Control state with synchronous reset; reset drops every buffered entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Payload write at the tail on every accepted int load.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            data_mem_q[wptr_q] <= returned_data_i;
            rd_mem_q[wptr_q]   <= returned_reg_id_i;
        end
    end

`ifndef SYNTHESIS
    // The core must never pop an empty FIFO.
    assert property (@(posedge clk_i) disable iff (reset_i)
        !(int_resp_yumi_i && (count_q == '0)))
        else $error("int_resp_yumi_i asserted while int FIFO empty");

    // A valid returned packet must carry a known type.
    assert property (@(posedge clk_i)
        returned_v_i |-> !$isunknown(returned_pkt_type_i))
        else $error("returned_v_i with unknown returned_pkt_type_i");
`endif

endmodule

// File: tb/tb_vanilla_returned_resp_buffer.sv
// Randomized plus directed bench for vanilla_returned_resp_buffer against a queue-based reference.
// Latency: one evaluation per clock; outputs sampled 1ns after the falling edge.
// Backpressure: bench never pops an empty FIFO and models the no-bypass full stall.
module tb_vanilla_returned_resp_buffer;

    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int ELS = 4;
    localparam int THR = ELS - 1;

    logic          clk_i;
    logic          reset_i;
    logic          returned_v_i;
    logic [DW-1:0] returned_data_i;
    logic [RW-1:0] returned_reg_id_i;
    logic [1:0]    returned_pkt_type_i;
    logic          returned_yumi_o;
    logic          int_resp_v_o;
    logic [RW-1:0] int_resp_rd_o;
    logic [DW-1:0] int_resp_data_o;
    logic          int_resp_force_o;
    logic          int_resp_yumi_i;
    logic          float_resp_v_o;
    logic [RW-1:0] float_resp_rd_o;
    logic [DW-1:0] float_resp_data_o;
    logic          ifetch_v_o;
    logic [DW-1:0] ifetch_instr_o;
    logic [2:0]    int_count_o;

    vanilla_returned_resp_buffer #(
        .data_width_p      (DW),
        .reg_addr_width_p  (RW),
        .els_p             (ELS),
        .force_threshold_p (THR)
    ) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .returned_v_i        (returned_v_i),
        .returned_data_i     (returned_data_i),
        .returned_reg_id_i   (returned_reg_id_i),
        .returned_pkt_type_i (returned_pkt_type_i),
        .returned_yumi_o     (returned_yumi_o),
        .int_resp_v_o        (int_resp_v_o),
        .int_resp_rd_o       (int_resp_rd_o),
        .int_resp_data_o     (int_resp_data_o),
        .int_resp_force_o    (int_resp_force_o),
        .int_resp_yumi_i     (int_resp_yumi_i),
        .float_resp_v_o      (float_resp_v_o),
        .float_resp_rd_o     (float_resp_rd_o),
        .float_resp_data_o   (float_resp_data_o),
        .ifetch_v_o          (ifetch_v_o),
        .ifetch_instr_o      (ifetch_instr_o),
        .int_count_o         (int_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, check 1ns later, advance the model at the rising edge.
    task automatic cycle(input logic rst, input logic v, input logic [1:0] t,
                         input logic [RW-1:0] rd, input logic [DW-1:0] d, input logic yi);
        int   sz;
        logic exp_yumi;
        logic live;
        @(negedge clk_i);
        reset_i             = rst;
        returned_v_i        = v;
        returned_pkt_type_i = t;
        returned_reg_id_i   = rd;
        returned_data_i     = d;
        int_resp_yumi_i     = yi;
        #1;
        sz       = q.size();
        live     = !rst && v;
        exp_yumi = live && (t != 2'd0 || sz < ELS);
        check("count",   32'(int_count_o),      32'(sz));
        check("yumi",    32'(returned_yumi_o),  32'(exp_yumi));
        check("float_v", 32'(float_resp_v_o),   32'(live && t == 2'd1));
        check("ifetch_v", 32'(ifetch_v_o),      32'(live && t == 2'd2));
        check("int_v",   32'(int_resp_v_o),     32'(!rst && sz != 0));
        check("force",   32'(int_resp_force_o), 32'(!rst && sz >= THR));
        if (live && t == 2'd1) begin
            check("float_rd",   32'(float_resp_rd_o), 32'(rd));
            check("float_data", float_resp_data_o,    d);
        end
        if (live && t == 2'd2)
            check("ifetch_instr", ifetch_instr_o, d);
        if (!rst && sz != 0) begin
            check("head_rd",   32'(int_resp_rd_o), 32'(q[0].rd));
            check("head_data", int_resp_data_o,    q[0].d);
        end
        @(posedge clk_i);
        if (rst) begin
            q.delete();
        end else begin
            if (sz != 0 && yi) void'(q.pop_front());
            if (exp_yumi && t == 2'd0) q.push_back('{rd, d});
        end
    endtask

    initial begin
        reset_i             = 1'b1;
        returned_v_i        = 1'b0;
        returned_pkt_type_i = 2'd0;
        returned_reg_id_i   = '0;
        returned_data_i     = '0;
        int_resp_yumi_i     = 1'b0;
        // Bring registers out of X before the model takes over.
        @(posedge clk_i);

        // Reset held, including a credit packet that must not be acked.
        cycle(1, 1, 2'd3, 5'd0, 32'h0, 0);
        cycle(1, 0, 2'd0, 5'd0, 32'h0, 0);

        // Float bypass, ifetch and credit-only.
        cycle(0, 1, 2'd1, 5'd7, 32'h3F800000, 0);
        check("float_exact", float_resp_data_o, 32'h3F800000);
        cycle(0, 1, 2'd2, 5'd0, 32'hDEADBEEF, 0);
        cycle(0, 1, 2'd3, 5'd0, 32'h0, 0);

        // Int ordering: 1,2,3 in, then drain; force tracks occupancy.
        for (int i = 1; i <= 3; i++) cycle(0, 1, 2'd0, 5'(i), 32'(100 + i), 0);
        for (int i = 0; i < 3; i++)  cycle(0, 0, 2'd0, 5'd0, 32'h0, 1);
        cycle(0, 0, 2'd0, 5'd0, 32'h0, 0);

        // Full: fifth int stalls even with a simultaneous pop, then goes in.
        for (int i = 0; i < 4; i++) cycle(0, 1, 2'd0, 5'(10 + i), 32'(200 + i), 0);
        cycle(0, 1, 2'd0, 5'd20, 32'hCAFE0005, 1);
        cycle(0, 1, 2'd0, 5'd20, 32'hCAFE0005, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 2'd0, 5'd0, 32'h0, 1);

        // Wrap: one entry, then ten enqueue/dequeue pairs back to back.
        cycle(0, 1, 2'd0, 5'd1, 32'h1000, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 2'd0, 5'(2 + i), 32'(32'h2000 + i), 1);
        cycle(0, 0, 2'd0, 5'd0, 32'h0, 1);

        // Reset mid-operation with three entries buffered.
        for (int i = 0; i < 3; i++) cycle(0, 1, 2'd0, 5'(i), 32'(300 + i), 0);
        cycle(1, 1, 2'd3, 5'd0, 32'h0, 0);
        cycle(0, 0, 2'd0, 5'd0, 32'h0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic          r, v, yi;
            logic [1:0]    t;
            r  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) != 0);
            t  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            yi = !r && (q.size() != 0) && ($urandom_range(0, 2) == 0);
            cycle(r, v, t, 5'($urandom), 32'($urandom), yi);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
